// File: rtl/dram_req_scheduler.sv
`timescale 1ns/1ps
// Two-port DRAM command scheduler: round-robin grant, single open-row tracking, PRE/ACT/CAS timing.
// Build option `DRAM_REQ_SCHEDULER_ROW_HIT_PRIO_EN lets the port hitting the open row win a tie.
module dram_req_scheduler #(
  parameter int T_RP  = 5,
  parameter int T_RCD = 5,
  parameter int T_WR  = 5
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  wstrb0,
  input  logic [3:0]  wstrb1,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        CSn,
  output logic        RASn,
  output logic        CASn,
  output logic [3:0]  WEn,
  output logic [10:0] A,
  output logic [31:0] D,
  input  logic [31:0] Q,
  input  logic        valid
);

  typedef enum logic [2:0] {IDLE, PRE, ACT, CAS, RWAIT, WWAIT, DONE} state_t;

  localparam logic [2:0] RP_LAST  = 3'(T_RP - 1);
  localparam logic [2:0] RCD_LAST = 3'(T_RCD - 1);
  localparam logic [2:0] WR_LAST  = 3'(T_WR - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic        gsel;
  logic        rr_last;
  logic        row_open;
  logic [10:0] open_row;

  logic        grant;
  logic        cur;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_we;
  logic [10:0] c_row;
  logic [10:0] c_col;
  logic [3:0]  cas_wen;
  logic        unused_addr_bits;

  assign CSn = 1'b0;
  assign unused_addr_bits = ^{addr0[31:23], addr0[1:0], addr1[31:23], addr1[1:0]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    grant = ~rr_last;
    if (req == 2'b01)
      grant = 1'b0;
    else if (req == 2'b10)
      grant = 1'b1;
`ifdef DRAM_REQ_SCHEDULER_ROW_HIT_PRIO_EN
    else if (row_open && ((addr0[22:12] == open_row) != (addr1[22:12] == open_row)))
      grant = (addr1[22:12] == open_row);
`endif
    // In IDLE the port being decided is the combinational grant, afterwards the latched one.
    cur     = (state == IDLE) ? grant : gsel;
    c_addr  = cur ? addr1 : addr0;
    c_wdata = cur ? wdata1 : wdata0;
    c_we    = we[cur];
    c_row   = c_addr[22:12];
    c_col   = c_addr[12:2];
    cas_wen = c_we ? ~(cur ? wstrb1 : wstrb0) : 4'hf;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      gsel     <= 1'b0;
      rr_last  <= 1'b1;
      row_open <= 1'b0;
      open_row <= 11'd0;
      done     <= 2'b00;
      rdata    <= 32'd0;
      RASn     <= 1'b1;
      CASn     <= 1'b1;
      WEn      <= 4'hf;
      A        <= 11'd0;
      D        <= 32'd0;
    end else begin
      // NOTE: non-blocking only, so every branch below reads pre-edge register values.
      RASn <= 1'b1;
      CASn <= 1'b1;
      WEn  <= 4'hf;
      done <= 2'b00;
      cnt  <= cnt + 3'd1;
      case (state)
        IDLE: begin
          if (|req) begin
            gsel    <= grant;
            rr_last <= grant;
            cnt     <= 3'd0;
            if (!row_open) begin
              state    <= ACT;
              RASn     <= 1'b0;
              A        <= c_row;
              open_row <= c_row;
              row_open <= 1'b1;
            end else if (c_row == open_row) begin
              state <= CAS;
              CASn  <= 1'b0;
              A     <= c_col;
              WEn   <= cas_wen;
              if (c_we) D <= c_wdata;
            end else begin
              state    <= PRE;
              RASn     <= 1'b0;
              WEn      <= 4'h0;
              A        <= open_row;
              row_open <= 1'b0;
            end
          end
        end
        PRE: begin
          if (cnt == RP_LAST) begin
            state    <= ACT;
            cnt      <= 3'd0;
            RASn     <= 1'b0;
            A        <= c_row;
            open_row <= c_row;
            row_open <= 1'b1;
          end
        end
        ACT: begin
          if (cnt == RCD_LAST) begin
            state <= CAS;
            cnt   <= 3'd0;
            CASn  <= 1'b0;
            A     <= c_col;
            WEn   <= cas_wen;
            if (c_we) D <= c_wdata;
          end
        end
        CAS: begin
          state <= c_we ? WWAIT : RWAIT;
          cnt   <= 3'd0;
        end
        RWAIT: begin
          if (valid) begin
            rdata <= Q;
            state <= DONE;
            done  <= gsel ? 2'b10 : 2'b01;
          end
        end
        WWAIT: begin
          if (cnt == WR_LAST) begin
            state <= DONE;
            done  <= gsel ? 2'b10 : 2'b01;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_req_scheduler.sv
`timescale 1ns/1ps
// Bench for dram_req_scheduler: word-level reference memory + scoreboard, a pin-level DRAM model
// that enforces bank rules and timing, directed scenarios and randomized two-port traffic.
module tb_dram_req_scheduler;

  localparam int TRP  = 3;
  localparam int TRCD = 4;
  localparam int TWR  = 2;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [3:0]  wstrb0 = 0, wstrb1 = 0;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q = 0;
  logic        valid = 1'b0;

  dram_req_scheduler #(.T_RP(TRP), .T_RCD(TRCD), .T_WR(TWR)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wstrb0(wstrb0), .wstrb1(wstrb1), .done(done), .rdata(rdata),
    .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn), .A(A), .D(D),
    .Q(Q), .valid(valid)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef enum int {C_PRE, C_ACT, C_CAS} cmd_e;
  typedef struct { cmd_e kind; logic [10:0] a; logic [3:0] wen; logic [31:0] d; int cyc; } cmd_t;
  typedef struct { int port; int cyc; } done_t;
  typedef struct { logic is_read; logic [31:0] data; } exp_t;
  typedef struct { int due; logic [31:0] data; } pend_t;

  cmd_t  cmd_log[$];
  done_t done_log[$];
  exp_t  sb[2][$];
  pend_t pend[$];
  logic [31:0] rmem [int];
  logic [31:0] dmem [int];
  int lat_force = 0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Power-up contents of every word, indexed by byte address bits [22:2].
  function automatic logic [31:0] init_word(input logic [20:0] w);
    if (w == 21'h401) return 32'hDEADBEEF;
    return {11'h5A5, w} ^ 32'h3C3C_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [20:0] w);
    return rmem.exists(int'(w)) ? rmem[int'(w)] : init_word(w);
  endfunction

  // Issue one request on port p, record the expected outcome, wait for done, then drop req.
  task automatic port_txn(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    logic [31:0] cur;
    logic got;
    cur = ref_read(a[22:2]);
    e.is_read = ~w;
    e.data    = w ? 32'd0 : cur;
    if (w) rmem[int'(a[22:2])] = merge(cur, wd, ws);
    sb[p].push_back(e);
    if (p == 0) begin addr0 = a; wdata0 = wd; wstrb0 = ws; end
    else        begin addr1 = a; wdata1 = wd; wstrb1 = ws; end
    we[p]  = w;
    req[p] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge ACLK);
      got = done[p];
    end
    check($sformatf("done_seen_p%0d", p), 32'(got), 32'd1);
    @(posedge ACLK);
    #1;
    req[p] = 1'b0;
  endtask

  // Port 0 owns odd words (addr[2]=1), port 1 even words, so per-port order fixes every read value.
  task automatic rand_port(input int p, input int n);
    int rows[5];
    int row;
    logic [31:0] a;
    logic [3:0] ws;
    rows = '{1, 2, 3, 5, 7};
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge ACLK); #1; end
      row = rows[$urandom_range(0, 4)];
      a = (32'(row) << 12) | ($urandom & 32'h0000_0FF8) | ((p == 0) ? 32'h4 : 32'h0);
      ws = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      port_txn(p, 1'($urandom), a, $urandom, ws);
    end
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge ACLK);
          if (done != 2'b00) begin
            check("done_onehot", 32'($countones(done)), 32'd1);
            for (int p = 0; p < 2; p++) begin
              if (done[p]) begin
                done_log.push_back('{p, cyc});
                if (sb[p].size() == 0) begin
                  check($sformatf("done_unexpected_p%0d", p), 32'(done), 32'd0);
                end else begin
                  e = sb[p].pop_front();
                  if (e.is_read) check($sformatf("rdata_p%0d", p), rdata, e.data);
                end
              end
            end
          end
        end
      end
      begin : dram_model
        logic rst_now, bank_open, have_last;
        logic [10:0] bank_row;
        cmd_e last;
        int last_cyc, widx;
        logic [31:0] old;
        bank_open = 1'b0;
        have_last = 1'b0;
        bank_row  = 11'd0;
        last      = C_PRE;
        last_cyc  = 0;
        forever begin
          @(posedge ACLK);
          rst_now = !ARESETn;
          #1;
          valid = 1'b0;
          if (rst_now) begin
            bank_open = 1'b0;
            have_last = 1'b0;
            pend.delete();
          end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
              valid = 1'b1;
              Q = pend[0].data;
              void'(pend.pop_front());
            end
            if (!RASn && CASn) begin
              if (WEn == 4'h0) begin
                check("pre_needs_open_bank", 32'(bank_open), 32'd1);
                check("pre_row", 32'(A), 32'(bank_row));
                bank_open = 1'b0;
                cmd_log.push_back('{C_PRE, A, WEn, D, cyc});
                last = C_PRE;
              end else begin
                check("act_needs_closed_bank", 32'(bank_open), 32'd0);
                if (have_last && last == C_PRE) check("trp_gap", cyc - last_cyc, TRP);
                bank_open = 1'b1;
                bank_row  = A;
                cmd_log.push_back('{C_ACT, A, WEn, D, cyc});
                last = C_ACT;
              end
              have_last = 1'b1;
              last_cyc  = cyc;
            end else if (RASn && !CASn) begin
              check("cas_needs_open_bank", 32'(bank_open), 32'd1);
              if (have_last && last == C_ACT) check("trcd_gap", cyc - last_cyc, TRCD);
              check("cas_col_row_bit", 32'(A[10]), 32'(bank_row[0]));
              widx = int'({bank_row, A[9:0]});
              old  = dmem.exists(widx) ? dmem[widx] : init_word(21'(widx));
              if (WEn != 4'hf) dmem[widx] = merge(old, D, ~WEn);
              else pend.push_back('{cyc + ((lat_force != 0) ? lat_force : $urandom_range(1, 3)), old});
              cmd_log.push_back('{C_CAS, A, WEn, D, cyc});
              have_last = 1'b1;
              last      = C_CAS;
              last_cyc  = cyc;
            end
          end
        end
      end
      begin : watchdog
        repeat (40000) @(posedge ACLK);
        $display("FAIL watchdog: simulation still running after 40000 cycles, want finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_RASn", 32'(RASn), 32'd1);
    check("rst_CASn", 32'(CASn), 32'd1);
    check("rst_WEn", 32'(WEn), 32'hf);
    check("rst_A", 32'(A), 32'd0);
    check("rst_D", D, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_CSn", 32'(CSn), 32'd0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;

    // Read on closed bank: ACT then CAS, data from power-up contents
    cmd_log.delete(); done_log.delete(); lat_force = 2;
    port_txn(0, 1'b0, 32'h0000_1004, 32'd0, 4'h0);
    check("tA_ncmd", cmd_log.size(), 2);
    if (cmd_log.size() == 2) begin
      check("tA_act", 32'(cmd_log[0].kind), 32'(C_ACT));
      check("tA_act_A", 32'(cmd_log[0].a), 32'h001);
      check("tA_cas", 32'(cmd_log[1].kind), 32'(C_CAS));
      check("tA_cas_A", 32'(cmd_log[1].a), 32'h401);
      check("tA_cas_WEn", 32'(cmd_log[1].wen), 32'hf);
    end
    check("tA_rdata", rdata, 32'hDEADBEEF);
    check("tA_ndone", done_log.size(), 1);

    // Row-hit partial write from port 1
    cmd_log.delete(); done_log.delete();
    port_txn(1, 1'b1, 32'h0000_1008, 32'h1234_5678, 4'b0011);
    check("tB_ncmd", cmd_log.size(), 1);
    check("tB_ndone", done_log.size(), 1);
    if (cmd_log.size() == 1 && done_log.size() == 1) begin
      check("tB_cas", 32'(cmd_log[0].kind), 32'(C_CAS));
      check("tB_cas_A", 32'(cmd_log[0].a), 32'h402);
      check("tB_WEn", 32'(cmd_log[0].wen), 32'b1100);
      check("tB_D", cmd_log[0].d, 32'h1234_5678);
      check("tB_done_lat", done_log[0].cyc - cmd_log[0].cyc, TWR + 1);
      check("tB_done_port", done_log[0].port, 1);
    end

    // Row miss: PRE old row, ACT new row, CAS
    cmd_log.delete(); done_log.delete();
    port_txn(0, 1'b0, 32'h0000_2004, 32'd0, 4'h0);
    check("tC_ncmd", cmd_log.size(), 3);
    if (cmd_log.size() == 3) begin
      check("tC_pre", 32'(cmd_log[0].kind), 32'(C_PRE));
      check("tC_pre_A", 32'(cmd_log[0].a), 32'h001);
      check("tC_act_A", 32'(cmd_log[1].a), 32'h002);
      check("tC_act_gap", cmd_log[1].cyc - cmd_log[0].cyc, TRP);
      check("tC_cas_A", 32'(cmd_log[2].a), 32'h001);
      check("tC_cas_gap", cmd_log[2].cyc - cmd_log[1].cyc, TRCD);
    end

    // Both ports busy after reset: strict alternation starting with port 0
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    cmd_log.delete(); done_log.delete(); lat_force = 0;
    fork
      for (int k = 0; k < 4; k++) port_txn(0, 1'(k), 32'h0000_3004 + 32'(k) * 8, $urandom, 4'hf);
      for (int k = 0; k < 4; k++) port_txn(1, 1'(~k), 32'h0000_3000 + 32'(k) * 8, $urandom, 4'hf);
    join
    check("tD_ndone", done_log.size(), 8);
    if (done_log.size() == 8)
      for (int i = 0; i < 8; i++) check($sformatf("tD_order%0d", i), done_log[i].port, i % 2);

    // Tie with one port hitting the open row (row 3) after port 1 was served
    port_txn(1, 1'b0, 32'h0000_3010, 32'd0, 4'h0);
    done_log.delete();
    fork
      port_txn(0, 1'b0, 32'h0000_5004, 32'd0, 4'h0);
      port_txn(1, 1'b0, 32'h0000_3018, 32'd0, 4'h0);
    join
    check("tP_ndone", done_log.size(), 2);
    if (done_log.size() == 2)
`ifdef DRAM_REQ_SCHEDULER_ROW_HIT_PRIO_EN
      check("tP_first", done_log[0].port, 1);
`else
      check("tP_first", done_log[0].port, 0);
`endif

    // Reset pulse while waiting for read data
    cmd_log.delete(); lat_force = 3;
    addr0 = 32'h0000_3024; we[0] = 1'b0; req[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (cmd_log.size() > 0 && cmd_log[cmd_log.size() - 1].kind == C_CAS) break;
    end
    check("tE_cas_seen", 32'(cmd_log.size() > 0), 32'd1);
    @(negedge ACLK);
    ARESETn = 1'b0;
    req[0]  = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("tE_RASn", 32'(RASn), 32'd1);
    check("tE_CASn", 32'(CASn), 32'd1);
    check("tE_WEn", 32'(WEn), 32'hf);
    check("tE_done", 32'(done), 32'd0);
    @(posedge ACLK);
    #1;
    cmd_log.delete(); lat_force = 0;
    port_txn(1, 1'b0, 32'h0000_7000, 32'd0, 4'h0);
    if (cmd_log.size() > 0) begin
      check("tE_first_act", 32'(cmd_log[0].kind), 32'(C_ACT));
      check("tE_act_A", 32'(cmd_log[0].a), 32'h007);
    end

    // Randomized concurrent traffic
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (10) @(posedge ACLK);
    check("sb0_empty", sb[0].size(), 0);
    check("sb1_empty", sb[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
